// File: rtl/hex_7seg_scan_pkg.sv
// hex_7seg_scan_pkg: shared types and constants for the seven-segment scan controller.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package hex_7seg_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GUARD = 2'd1,
    DRIVE = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam int         MAX_DIGITS = 8;
  localparam int         IDX_W      = 3;
  localparam int         EXT_W      = 4 * MAX_DIGITS;

  // Index of the most significant nonzero nibble; 0 when the whole value is zero,
  // so digit 0 is always considered significant.
  function automatic logic [IDX_W-1:0] top_nonzero(input logic [EXT_W-1:0] v);
    top_nonzero = '0;
    for (int k = 1; k < MAX_DIGITS; k++) begin
      if (v[4*k +: 4] != 4'h0) top_nonzero = IDX_W'(k);
    end
  endfunction

endpackage

// File: rtl/hex_7seg.sv
// hex_7seg: hex nibble to active-low seven-segment pattern {g,f,e,d,c,b,a}.
// Latency: combinational.
// Backpressure: none.
module hex_7seg (
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  // Lookup of the glyph for each hex digit (0 = segment lit).
  always_comb begin
    seg_n = 7'h7F;
    case (nibble)
      4'h0: seg_n = 7'h40;
      4'h1: seg_n = 7'h79;
      4'h2: seg_n = 7'h24;
      4'h3: seg_n = 7'h30;
      4'h4: seg_n = 7'h19;
      4'h5: seg_n = 7'h12;
      4'h6: seg_n = 7'h02;
      4'h7: seg_n = 7'h78;
      4'h8: seg_n = 7'h00;
      4'h9: seg_n = 7'h10;
      4'hA: seg_n = 7'h08;
      4'hB: seg_n = 7'h03;
      4'hC: seg_n = 7'h46;
      4'hD: seg_n = 7'h21;
      4'hE: seg_n = 7'h06;
      4'hF: seg_n = 7'h0E;
      default: seg_n = 7'h7F;
    endcase
  end

endmodule

// File: rtl/hex_7seg_scan.sv
// hex_7seg_scan: time-multiplexed scanner sharing one hex_7seg decoder across NUM_DIGITS common-anode digits.
// Latency: seg_n/an_n registered one cycle behind the scan state; a load shows within one frame + BLANK_CYCLES + 1.
// Backpressure: none; load is taken every cycle and the last value before a frame boundary wins.
// Option: define HEX_7SEG_SCAN_LZB_EN for leading-zero blanking.
module hex_7seg_scan
  import hex_7seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  output logic                    update_pending,
  output logic                    frame_start,
  output logic [6:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   an_n
);

  localparam int                   CW         = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0]        GUARD_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0]        DRIVE_LAST = CW'(REFRESH_DIV - BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0]     IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF    = '1;
  localparam logic [NUM_DIGITS-1:0] AN_ONE    = NUM_DIGITS'(1);

  state_t                  state, state_nx;
  logic [CW-1:0]           cnt, cnt_nx;
  logic [IDX_W-1:0]        idx, idx_nx;
  logic                    boundary;
  logic [4*NUM_DIGITS-1:0] display, pending;
  logic [EXT_W-1:0]        disp_ext;
  logic [3:0]              nibble;
  logic [6:0]              seg_dec, seg_nx;
  logic [NUM_DIGITS-1:0]   an_nx;
  logic                    lit;

  assign disp_ext = EXT_W'(display);
  assign nibble   = disp_ext[{idx, 2'b00} +: 4];

  hex_7seg u_dec (
    .nibble (nibble),
    .seg_n  (seg_dec)
  );

`ifdef HEX_7SEG_SCAN_LZB_EN
  // Digits above the most significant nonzero nibble stay dark.
  assign lit = (idx <= top_nonzero(disp_ext));
`else
  assign lit = 1'b1;
`endif

  // The boundary decision is combinational so a load in the same cycle can bypass pending;
  // it is masked during reset so the pulse reads 0 while the FSM is held.
  assign frame_start = boundary & ~rst;

  // Scan state register: state, slot counter and digit index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
    end
  end

  // Next-state, boundary detection and next pin values.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    boundary = 1'b0;
    seg_nx   = SEG_BLANK;
    an_nx    = AN_OFF;
    if (!enable) begin
      state_nx = IDLE;
      cnt_nx   = '0;
      idx_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nx = GUARD;
          cnt_nx   = '0;
          idx_nx   = '0;
          boundary = 1'b1;
        end
        GUARD: begin
          if (cnt == GUARD_LAST) begin
            state_nx = DRIVE;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        DRIVE: begin
          if (cnt == DRIVE_LAST) begin
            state_nx = GUARD;
            cnt_nx   = '0;
            if (idx == IDX_LAST) begin
              idx_nx   = '0;
              boundary = 1'b1;
            end else begin
              idx_nx = idx + IDX_W'(1);
            end
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
          idx_nx   = '0;
        end
      endcase
    end
    if (state == DRIVE && lit) begin
      seg_nx = seg_dec;
      an_nx  = ~(AN_ONE << idx);
    end
  end

  // Pending capture and frame-boundary swap into the display register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      display        <= '0;
      pending        <= '0;
      update_pending <= 1'b0;
    end else if (boundary) begin
      if (load) begin
        display <= value;
      end else if (update_pending) begin
        display <= pending;
      end
      update_pending <= 1'b0;
    end else if (load) begin
      pending        <= value;
      update_pending <= 1'b1;
    end
  end

  // Pin registers keep segments and anodes glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_n <= SEG_BLANK;
      an_n  <= AN_OFF;
    end else begin
      seg_n <= seg_nx;
      an_n  <= an_nx;
    end
  end

endmodule

// File: doc/hex_7seg_scan.md
# hex_7seg_scan

Time-multiplexed scan controller that shares one `hex_7seg` decoder across `NUM_DIGITS` common-anode seven-segment digits. It latches a packed hex value and cycles through the digits, driving one anode at a time. Each digit slot begins with a blanking guard to suppress ghosting. Display updates are deferred to frame boundaries so a frame never shows a mix of old and new digits. It sits between user logic that produces a display value and the board's segment and anode pins.

## Interface
- `NUM_DIGITS`, 4: number of digits, legal range 1..8.
- `REFRESH_DIV`, 50000: clock cycles per digit slot.
- `BLANK_CYCLES`, 16: guard cycles at the start of each slot. Must satisfy 1 ≤ `BLANK_CYCLES` < `REFRESH_DIV`.
- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  scan enable. When low, the display is dark.
- `value`  in  4*NUM_DIGITS  packed nibbles. Nibble k drives digit k; digit 0 is the least significant.
- `load`  in  1  single-cycle strobe that captures `value` into the pending register.
- `update_pending`  out  1  high while a captured value is waiting for the next frame boundary.
- `frame_start`  out  1  one-cycle pulse in the boundary cycle of each frame.
- `seg_n`  out  7  active-low segments {g,f,e,d,c,b,a}. The blank pattern is 7'h7F.
- `an_n`  out  NUM_DIGITS  active-low anodes. At most one bit is low at any time.

## Operation
- State machine with three states: IDLE, GUARD, DRIVE.
- IDLE
  - All anodes off, `seg_n`=7'h7F.
  - When `enable`=1, go to GUARD with digit 0 and perform the frame-boundary swap.
- GUARD
  - Anodes off, `seg_n`=7'h7F.
  - Lasts `BLANK_CYCLES` cycles, then goes to DRIVE.
- DRIVE
  - `an_n[idx]`=0 and `seg_n` = decode(display nibble idx).
  - Lasts `REFRESH_DIV`−`BLANK_CYCLES` cycles, then goes to GUARD with idx+1.
  - When idx = `NUM_DIGITS`−1, idx wraps to 0 and the move to digit 0 is a frame boundary.
- Frame-boundary swap (entering GUARD for digit 0):
  - If `load`=1 in that cycle, display ← `value`. The same-cycle load bypasses the pending register.
  - Otherwise, if `update_pending`=1, display ← pending.
  - `update_pending` clears in both cases.
  - `frame_start` pulses in this cycle.
- `load` at any other time: pending ← `value` and `update_pending` is set. A later load overwrites an earlier one; the last value wins.
- `enable` falling in any state: go to IDLE next cycle and clear the slot counter and idx. The display and pending registers are kept. Re-enabling always restarts at digit 0 with a fresh frame.
- Slot counter width is $clog2(`REFRESH_DIV`). It counts 0..limit−1 in each state, with no overflow beyond the limit.

## Timing
- Reset values:
  - state IDLE
  - `seg_n`=7'h7F
  - `an_n`=all ones
  - `frame_start`=0
  - `update_pending`=0
  - display register = 0
  - pending register = 0
  - counters = 0
- `seg_n` and `an_n` are registered and lag the state by exactly one cycle. This makes them glitch-free at the pins.
- Frame period is `NUM_DIGITS`×`REFRESH_DIV` cycles. An anode is low for `REFRESH_DIV`−`BLANK_CYCLES` cycles per slot.
- Latency from `load` to visible change is at most one frame plus `BLANK_CYCLES`+1 cycles.
- Reset asserted mid-operation forces all reset values immediately, asynchronously.
- `load` while `enable`=0 still captures into pending. The value is shown on the first frame after enable.

## Configuration
- `HEX_7SEG_SCAN_LZB_EN` defined: leading-zero blanking.
  - Digits above the most significant nonzero nibble of the display register show `seg_n`=7'h7F with their anode held high.
  - Digit 0 is never blanked, so a value of 0 still shows "0".
  - Slot timing is unchanged.
- `HEX_7SEG_SCAN_LZB_EN` undefined: every digit is always driven.

## Structure
- `hex_7seg_scan_pkg` holds:
  - the state enum (IDLE, GUARD, DRIVE)
  - `SEG_BLANK`=7'h7F
  - `MAX_DIGITS`=8
- One sub-module: a single `hex_7seg` instance. Its input is the nibble selected by idx; its output feeds the `seg_n` register.

## Test plan
Parameters for the bench: NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
- Reset hold:
  - Stimulus: `rst`=1 and `enable`=1.
  - Required: `seg_n`=7'h7F, `an_n`=4'hF, `update_pending`=0 throughout.
- Basic scan:
  - Stimulus: `load` 16'h12AF, then hold `enable`=1.
  - Required: the first frame shows digits 0..3 as F,A,2,1. That is `seg_n`=7'h0E on `an_n`=4'hE, 7'h08 on 4'hD, 7'h24 on 4'hB, 7'h79 on 4'h7.
  - Required: each digit is lit 6 cycles after 2 blank cycles.
  - Required: `frame_start` pulses every 32 cycles.
- Deferred update:
  - Stimulus: `load` 16'h0005 during the digit-2 slot.
  - Required: `update_pending`=1 until the next frame boundary; the old digits stay visible until then; after the boundary, digit 0 shows 7'h12.
- Boundary bypass:
  - Stimulus: `load` 16'h3333 in the `frame_start` cycle while pending holds 16'h4444.
  - Required: the frame shows 3333.
- Enable drop:
  - Stimulus: deassert `enable` mid-slot of digit 1, then reassert it.
  - Required: `an_n`=4'hF one cycle after the drop; scanning resumes at digit 0 after 2 guard cycles.
- Leading-zero blanking (`HEX_7SEG_SCAN_LZB_EN` defined):
  - Stimulus: value 16'h0050.
  - Required: digits 2 and 3 have anodes off; digit 1 shows 7'h12; digit 0 shows 7'h40.
  - Stimulus: value 0.
  - Required: only digit 0 is lit.
